// File: rtl/isa_pkg.sv
// ISA definitions shared by the instruction encoder and decoder: opcodes, operand
// formats and which register fields each format actually reads or writes.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,  OP_ALU    = 4'd1,  OP_ADDI   = 4'd2,  OP_XORI   = 4'd3,
        OP_MOV    = 4'd4,  OP_SHIFT  = 4'd5,  OP_MULT   = 4'd6,  OP_HASH   = 4'd7,
        OP_RDRAM  = 4'd8,  OP_WRRAM  = 4'd9,  OP_JUMP   = 4'd10, OP_WRIMM  = 4'd11,
        OP_CJUMP  = 4'd12, OP_RSVD13 = 4'd13, OP_RSVD14 = 4'd14, OP_HALT   = 4'd15
    } opcode_e;

    typedef enum logic [3:0] {
        FMT_NONE, FMT_RRW, FMT_RRI, FMT_RW, FMT_RIW, FMT_RR, FMT_WI, FMT_J, FMT_RSVD
    } fmt_e;

    // Field-use mask bit order is {wreg, rreg1, rreg0}
    localparam logic [2:0] USE_R0 = 3'b001;
    localparam logic [2:0] USE_R1 = 3'b010;
    localparam logic [2:0] USE_W  = 3'b100;

    function automatic fmt_e op_fmt(input opcode_e op);
        fmt_e f;
        case (op)
            OP_ALU, OP_MULT:             f = FMT_RRW;
            OP_CJUMP:                    f = FMT_RRI;
            OP_MOV, OP_SHIFT, OP_HASH:   f = FMT_RW;
            OP_RDRAM:                    f = FMT_RIW;
            OP_WRRAM:                    f = FMT_RR;
            OP_ADDI, OP_XORI, OP_WRIMM:  f = FMT_WI;
            OP_JUMP:                     f = FMT_J;
            OP_RSVD13, OP_RSVD14:        f = FMT_RSVD;
            default:                     f = FMT_NONE;
        endcase
        return f;
    endfunction

    function automatic logic [2:0] fmt_use(input fmt_e f);
        logic [2:0] m;
        case (f)
            FMT_RRW: m = USE_R0 | USE_R1 | USE_W;
            FMT_RRI: m = USE_R0 | USE_R1;
            FMT_RW:  m = USE_R0 | USE_W;
            FMT_RIW: m = USE_R0 | USE_W;
            FMT_RR:  m = USE_R0 | USE_R1;
            FMT_WI:  m = USE_W;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: opcode, physical registers and immediate into the 16-bit
// ISA word, plus the mask of register fields the format depends on.
module instr_pack
    import isa_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  wreg,
    input  logic [4:0]  rreg0,
    input  logic [4:0]  rreg1,
    input  logic [11:0] imm,
    output logic [15:0] word,
    output logic [2:0]  use_mask,
    output logic        illegal
);
    fmt_e       fmt;
    logic [3:0] a, b, c;

    always_comb begin
        fmt = op_fmt(opcode_e'(op));
        a   = 4'd0;
        b   = 4'd0;
        c   = 4'd0;
        // Register index is the physical ID without its valid LSB
        case (fmt)
            FMT_RRW: begin a = rreg0[4:1]; b = rreg1[4:1]; c = wreg[4:1]; end
            FMT_RRI: begin a = rreg0[4:1]; b = rreg1[4:1]; c = imm[3:0];  end
            FMT_RW:  begin a = rreg0[4:1]; c = wreg[4:1];                 end
            FMT_RIW: begin a = rreg0[4:1]; b = imm[3:0];   c = wreg[4:1]; end
            FMT_RR:  begin a = rreg0[4:1]; b = rreg1[4:1];                end
            FMT_WI:  begin a = wreg[4:1];  {b, c} = imm[7:0];             end
            FMT_J:   {a, b, c} = imm;
            default: ;
        endcase
        word     = {a, b, c, op};
        use_mask = fmt_use(fmt);
        illegal  = (fmt == FMT_RSVD);
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams checked, packed instructions into IMEM at consecutive addresses until a
// HALT has been written or a beat fails its field checks.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_wreg,
    input  logic [4:0]        in_rreg0,
    input  logic [4:0]        in_rreg1,
    input  logic [11:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state_q, state_d;
    logic              halt_seen_q, halt_seen_d, halt_pend_q, halt_pend_d;
    logic              mem_we_q, mem_we_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        err_code_q, err_code_d, code;
    logic [ADDR_W:0]   count_q, count_d;
    logic [15:0]       word;
    logic [2:0]        use_mask;
    logic              illegal, reg_miss, hs, beat;

    instr_pack u_pack (
        .op       (in_op),
        .wreg     (in_wreg),
        .rreg0    (in_rreg0),
        .rreg1    (in_rreg1),
        .imm      (in_imm),
        .word     (word),
        .use_mask (use_mask),
        .illegal  (illegal)
    );

    assign in_ready = (state_q == S_RUN) && !halt_seen_q && (!mem_we_q || mem_ready);
    assign beat     = in_valid && in_ready;
    assign hs       = mem_we_q && mem_ready;
    assign reg_miss = |(use_mask & {~in_wreg[0], ~in_rreg1[0], ~in_rreg0[0]});

    always_comb begin
        state_d     = state_q;
        halt_seen_d = halt_seen_q;
        halt_pend_d = halt_pend_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        count_d     = count_q;
        code        = 2'd0;

        if (hs) begin
            mem_we_d    = 1'b0;
            halt_pend_d = 1'b0;
            count_d     = count_q + (ADDR_W+1)'(1);
            if (halt_pend_q) begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
        end

        // A beat only happens with no write left pending after this cycle,
        // so count_d is the exact number of words already in IMEM.
        if (beat) begin
            if (illegal)              code = 2'd1;
            else if (reg_miss)        code = 2'd2;
            else if (count_d == FULL) code = 2'd3;

            if (code != 2'd0) begin
                err_d      = 1'b1;
                err_code_d = code;
                state_d    = S_ERR;
            end else begin
                mem_we_d    = 1'b1;
                mem_addr_d  = count_d[ADDR_W-1:0];
                mem_wdata_d = word;
                halt_pend_d = (in_op == OP_HALT);
                halt_seen_d = (in_op == OP_HALT);
            end
        end

        if (start && state_q != S_RUN) begin
            state_d     = S_RUN;
            count_d     = '0;
            mem_addr_d  = '0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            err_code_d  = 2'd0;
            halt_seen_d = 1'b0;
            halt_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            halt_seen_q <= 1'b0;
            halt_pend_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            halt_seen_q <= halt_seen_d;
            halt_pend_q <= halt_pend_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            count_q     <= count_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == S_RUN) || mem_we_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Drives a full-size (ADDR_W=8) and a tiny (ADDR_W=2) encoder with the same stream and
// checks both against a transaction-level model of the loader.
module tb_instr_encoder;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, mem_ready = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_wreg = '0, in_rreg0 = '0, in_rreg1 = '0;
    logic [11:0] in_imm = '0;

    logic        rdy0, we0, busy0, done0, err0;
    logic [7:0]  addr0;
    logic [15:0] wd0;
    logic [1:0]  ec0;
    logic [8:0]  cnt0;
    logic        rdy1, we1, busy1, done1, err1;
    logic [1:0]  addr1;
    logic [15:0] wd1;
    logic [1:0]  ec1;
    logic [2:0]  cnt1;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy0),
        .in_op(in_op), .in_wreg(in_wreg), .in_rreg0(in_rreg0), .in_rreg1(in_rreg1),
        .in_imm(in_imm), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .mem_ready(mem_ready), .busy(busy0), .done(done0), .err(err0), .err_code(ec0),
        .count(cnt0));

    instr_encoder #(.ADDR_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy1),
        .in_op(in_op), .in_wreg(in_wreg), .in_rreg0(in_rreg0), .in_rreg1(in_rreg1),
        .in_imm(in_imm), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .mem_ready(mem_ready), .busy(busy1), .done(done1), .err(err1), .err_code(ec1),
        .count(cnt1));

    // Loader model: one entry per DUT instance
    int          cap[2] = '{256, 4};
    bit          m_run[2], m_halt[2], m_pend[2], m_phalt[2], m_done[2], m_err[2], m_rdy[2];
    int          m_code[2], m_count[2], m_addr[2];
    logic [15:0] m_word[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_word(int op, int w, int r0, int r1, int imm);
        int a = 0, b = 0, c = 0;
        case (op)
            1, 6:     begin a = r0 / 2; b = r1 / 2; c = w / 2; end
            12:       begin a = r0 / 2; b = r1 / 2; c = imm % 16; end
            4, 5, 7:  begin a = r0 / 2; c = w / 2; end
            8:        begin a = r0 / 2; b = imm % 16; c = w / 2; end
            9:        begin a = r0 / 2; b = r1 / 2; end
            2, 3, 11: begin a = w / 2; b = (imm / 16) % 16; c = imm % 16; end
            10:       begin a = imm / 256; b = (imm / 16) % 16; c = imm % 16; end
            default:  ;
        endcase
        return 16'(a * 4096 + b * 256 + c * 16 + op);
    endfunction

    function automatic int ref_code(int op, int w, int r0, int r1);
        bit uw, u0, u1;
        if (op == 13 || op == 14) return 1;
        uw = op inside {1, 2, 3, 4, 5, 6, 7, 8, 11};
        u0 = op inside {1, 4, 5, 6, 7, 8, 9, 12};
        u1 = op inside {1, 6, 9, 12};
        if ((uw && w % 2 == 0) || (u0 && r0 % 2 == 0) || (u1 && r1 % 2 == 0)) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_halt[i] = 0; m_pend[i] = 0; m_phalt[i] = 0;
            m_done[i] = 0; m_err[i] = 0; m_code[i] = 0; m_count[i] = 0;
            m_addr[i] = 0; m_word[i] = '0;
        end
    endtask

    task automatic model_step(int i, bit st, bit v, int op, int w, int r0, int r1, int imm, bit mr);
        bit was_run, hs, beat;
        int cnt, code;
        was_run  = m_run[i];
        hs       = m_pend[i] && mr;
        m_rdy[i] = m_run[i] && !m_halt[i] && (!m_pend[i] || mr);
        beat     = v && m_rdy[i];
        cnt      = m_count[i] + (hs ? 1 : 0);
        if (hs) begin
            m_pend[i] = 0;
            if (m_phalt[i]) begin m_phalt[i] = 0; m_done[i] = 1; m_run[i] = 0; end
        end
        if (beat) begin
            code = ref_code(op, w, r0, r1);
            if (code == 0 && cnt == cap[i]) code = 3;
            if (code != 0) begin
                m_err[i] = 1; m_code[i] = code; m_run[i] = 0;
            end else begin
                m_pend[i] = 1; m_addr[i] = cnt; m_word[i] = ref_word(op, w, r0, r1, imm);
                m_phalt[i] = (op == 15);
                if (op == 15) m_halt[i] = 1;
            end
        end
        m_count[i] = cnt;
        if (st && !was_run) begin
            m_run[i] = 1; m_count[i] = 0; m_addr[i] = 0; m_done[i] = 0; m_err[i] = 0;
            m_code[i] = 0; m_halt[i] = 0; m_phalt[i] = 0;
        end
    endtask

    task automatic check_all();
        chk("we0",   32'(we0),   32'(m_pend[0]));
        chk("addr0", 32'(addr0), 32'(m_addr[0]));
        chk("wd0",   32'(wd0),   32'(m_word[0]));
        chk("busy0", 32'(busy0), 32'(m_run[0] || m_pend[0]));
        chk("done0", 32'(done0), 32'(m_done[0]));
        chk("err0",  32'(err0),  32'(m_err[0]));
        chk("ec0",   32'(ec0),   32'(m_code[0]));
        chk("cnt0",  32'(cnt0),  32'(m_count[0]));
        chk("we1",   32'(we1),   32'(m_pend[1]));
        chk("addr1", 32'(addr1), 32'(m_addr[1]));
        chk("wd1",   32'(wd1),   32'(m_word[1]));
        chk("busy1", 32'(busy1), 32'(m_run[1] || m_pend[1]));
        chk("done1", 32'(done1), 32'(m_done[1]));
        chk("err1",  32'(err1),  32'(m_err[1]));
        chk("ec1",   32'(ec1),   32'(m_code[1]));
        chk("cnt1",  32'(cnt1),  32'(m_count[1]));
    endtask

    // Called at a negedge: drive, predict, check in_ready before the edge, check state after.
    task automatic cyc(bit st, bit v, int op, int w, int r0, int r1, int imm, bit mr);
        start = st; in_valid = v; in_op = 4'(op); in_wreg = 5'(w);
        in_rreg0 = 5'(r0); in_rreg1 = 5'(r1); in_imm = 12'(imm); mem_ready = mr;
        for (int i = 0; i < 2; i++) model_step(i, st, v, op, w, r0, r1, imm, mr);
        #1;
        chk("rdy0", 32'(rdy0), 32'(m_rdy[0]));
        chk("rdy1", 32'(rdy1), 32'(m_rdy[1]));
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(bit mr);
        cyc(0, 0, 0, 0, 0, 0, 0, mr);
    endtask

    initial begin
        int op, w, r0, r1;
        model_reset();
        #12;
        check_all();
        chk("rst_rdy", 32'(rdy0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // ALU r1,r2->r3 ; JUMP 0x123 ; HALT with IMEM always ready
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("start_rdy", 32'(rdy0), 32'd1);
        cyc(0, 1, 1, 7, 3, 5, 0, 1);
        chk("alu_word", 32'(wd0), 32'h1231);
        chk("alu_addr", 32'(addr0), 32'd0);
        cyc(0, 1, 10, 0, 0, 0, 'h123, 1);
        chk("jump_word", 32'(wd0), 32'h123A);
        chk("jump_addr", 32'(addr0), 32'd1);
        cyc(0, 1, 15, 0, 0, 0, 0, 1);
        chk("halt_word", 32'(wd0), 32'h000F);
        chk("halt_addr", 32'(addr0), 32'd2);
        cyc(0, 1, 1, 7, 3, 5, 0, 1);
        chk("halt_done", 32'(done0), 32'd1);
        chk("halt_cnt", 32'(cnt0), 32'd3);
        chk("halt_rdy", 32'(rdy0), 32'd0);

        // ADDI restarted at address 0, then a 4-cycle IMEM stall with a beat waiting
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 2, 7, 0, 0, 'hA5, 0);
        chk("addi_word", 32'(wd0), 32'h3A52);
        chk("addi_addr", 32'(addr0), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 4, 9, 11, 0, 0, 0);
            chk("stall_word", 32'(wd0), 32'h3A52);
        end
        cyc(0, 1, 4, 9, 11, 0, 0, 1);
        chk("addi_cnt", 32'(cnt0), 32'd1);
        chk("mov_word", 32'(wd0), 32'h5044);
        chk("mov_addr", 32'(addr0), 32'd1);
        idle(1);

        // Reserved opcode, then a source register without its valid bit
        cyc(0, 1, 13, 1, 1, 1, 0, 1);
        chk("rsvd_code", 32'(ec0), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 7, 6, 5, 0, 1);
        chk("lsb_code", 32'(ec0), 32'd2);
        chk("lsb_we", 32'(we0), 32'd0);

        // Fill the tiny image: four NOPs land, the fifth beat reports full
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 0, 0, 1);
        chk("full_code", 32'(ec1), 32'd3);
        chk("full_cnt", 32'(cnt1), 32'd4);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("full_clr", 32'(cnt1), 32'd0);

        // Async reset in the middle of a stalled write
        cyc(0, 1, 2, 3, 0, 0, 'h12, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_we", 32'(we0), 32'd0);
        check_all();
        start = 0; in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("arst_rdy", 32'(rdy0), 32'd1);

        // Random traffic with restarts
        for (int n = 0; n < 4000; n++) begin
            op = $urandom_range(0, 15);
            if ((op == 13 || op == 14 || op == 15) && $urandom_range(0, 3) != 0) op = 1;
            w  = $urandom_range(0, 31) | ($urandom_range(0, 9) != 0 ? 1 : 0);
            r0 = $urandom_range(0, 31) | ($urandom_range(0, 9) != 0 ? 1 : 0);
            r1 = $urandom_range(0, 31) | ($urandom_range(0, 9) != 0 ? 1 : 0);
            cyc(($urandom_range(0, 31) == 0) || (!m_run[0] && $urandom_range(0, 3) == 0),
                $urandom_range(0, 3) != 0, op, w, r0, r1, $urandom_range(0, 4095),
                $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
